data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Multi-cycle data-memory responder serving the pipeline's MEM-stage load/store requests over a valid/ready handshake. Replaces the zero-latency combinational data memory so the datapath can be exercised against realistic memory latency. Holds one outstanding request. Performs byte/half/word access with sign or zero extension, and flags misaligned or out-of-range addresses.

## Interface
Parameters:
- DEPTH_WORDS, 1024: memory size in 32-bit words.
- LATENCY, 2: cycles from request accept to `resp_valid`; legal values are 1 to 15.

Ports:
- Clk  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high exactly when the state is IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the lane data is taken from the low bits.
- req_type  in  2  access size: 00 = word, 01 = half, 10 = byte, 11 = reserved and treated as word.
- req_unsigned  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  load result, already extended; 0 for stores and for errors.
- resp_err  out  1  misaligned or out-of-range access.

## Operation
States:
- IDLE: `req_ready` = 1. When `req_valid` is high, the request is accepted. The block latches `write`, `addr`, `wdata`, `type` and `unsigned`.
  - If LATENCY = 1, the next state is RESP.
  - Otherwise the next state is WAIT, with `cnt` = LATENCY-2.
- WAIT: `cnt` decrements each cycle. When `cnt` = 0, the next state is RESP.
- RESP entry: the access executes on the edge that enters RESP.
  - A store updates only the addressed lanes.
  - `resp_rdata` and `resp_err` are registered on that same edge.
- RESP: `resp_valid` = 1 and the outputs hold stable until `resp_valid && resp_ready`. The next state is then IDLE.

Access rules:
- Lanes are little-endian: byte n of a word sits at bits [8n+7:8n].
- Misaligned access:
  - half with `addr[0]` = 1;
  - word or reserved type with `addr[1:0]` ≠ 0.
- Out of range: `addr[31:2]` ≥ DEPTH_WORDS.
- On any error: no write, `resp_rdata` = 0, `resp_err` = 1. The response still completes through the normal handshake.

Boundary conditions:
- Reset in WAIT or RESP abandons the request. A store not yet committed (still in WAIT) never writes memory.
- Reset does not clear memory contents.
- `req_valid` outside IDLE is ignored; the requester must hold the request until accepted.
- Back-to-back requests: no IDLE bypass. The minimum initiation interval is LATENCY+1 cycles with `resp_ready` tied high.
- Memory is word-organised: `mem[addr[31:2]]`.

## Timing
- Reset values:
  - state = IDLE, so `req_ready` = 1 on the first cycle after reset;
  - `resp_valid` = 0;
  - `resp_rdata` = 0;
  - `resp_err` = 0;
  - `cnt` = 0.
- Accept edge T, meaning `req_valid && req_ready` is high at edge T:
  - `resp_valid` rises after edge T+LATENCY-1;
  - it is therefore first sampled high at edge T+LATENCY.
- Response backpressure: if `resp_ready` is low, RESP holds indefinitely.
- No combinational path from `req_*` to `resp_*`. `req_ready` is a decode of registered state only.

## Structure
- Shared package `mem_pkg`:
  - size encodings `MEM_WORD`, `MEM_HALF`, `MEM_BYTE`;
  - state encoding `ST_IDLE`, `ST_WAIT`, `ST_RESP`.
- The pipeline's controller uses the same `mem_pkg` size encodings for its `dataType` field.
- One sub-module, `mem_lane_align` (combinational):
  - inputs: `addr[1:0]`, `type`, `unsigned`, `wdata`, memory word;
  - outputs: 4-bit byte-enable, aligned write word, extended read data, misaligned flag.
- The top level holds the FSM, the latency counter and the memory array.

## Test plan
- Word store/load, LATENCY=2: store 0xDEADBEEF to 0x10, then load word 0x10 → `rdata` 0xDEADBEEF, `err` 0, `resp_valid` sampled high 2 edges after accept.
- Byte/half extension: after the word store above:
  - load byte signed at 0x13 → 0xFFFFFFDE;
  - load byte unsigned at 0x13 → 0x000000DE;
  - load half signed at 0x10 → 0xFFFFBEEF.
- Partial store: store byte 0x55 to 0x11 over 0xDEADBEEF → word load at 0x10 returns 0xDEAD55EF.
- Errors:
  - half load at 0x21 → `err` 1, `rdata` 0;
  - word store at 0x22 → `err` 1, memory at 0x20 unchanged;
  - word load at 4*DEPTH_WORDS → `err` 1.
- Backpressure: hold `resp_ready` low for 5 cycles in RESP → `resp_valid` and `rdata` stable and `req_ready` 0; release → return to IDLE the next cycle.
- Reset mid-op: assert `Reset` one cycle after accepting a store of 0x12345678 to 0x40 (LATENCY=3) → `resp_valid` never rises, `req_ready` is 1 after reset, and a subsequent load at 0x40 returns the old value.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-access encodings used by the data-memory responder and the
// pipeline controller's dataType field.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_WORD = 2'b00,
    MEM_HALF = 2'b01,
    MEM_BYTE = 2'b10,
    MEM_RSVD = 2'b11
  } memSizeT;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } respStateT;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for word-organised memory: write byte-enables and lane
// replication, read lane extraction with sign/zero extension, alignment check.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  addrLo,
  input  logic [1:0]  accType,
  input  logic        isUnsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] memWord,
  output logic [3:0]  byteEn,
  output logic [31:0] wordOut,
  output logic [31:0] rdata,
  output logic        misaligned
);

  logic [15:0] halfSel;
  logic [7:0]  byteSel;

  always_comb begin
    byteEn     = '0;
    wordOut    = '0;
    rdata      = '0;
    misaligned = 1'b0;
    halfSel    = addrLo[1] ? memWord[31:16] : memWord[15:0];
    byteSel    = memWord[{addrLo, 3'b000} +: 8];
    case (accType)
      MEM_HALF: begin
        misaligned = addrLo[0];
        byteEn     = addrLo[1] ? 4'b1100 : 4'b0011;
        wordOut    = {2{wdata[15:0]}};
        rdata      = isUnsigned ? {16'h0000, halfSel} : {{16{halfSel[15]}}, halfSel};
      end
      MEM_BYTE: begin
        byteEn  = 4'b0001 << addrLo;
        wordOut = {4{wdata[7:0]}};
        rdata   = isUnsigned ? {24'h000000, byteSel} : {{24{byteSel[7]}}, byteSel};
      end
      default: begin
        // reserved size behaves as a full word
        misaligned = (addrLo != 2'b00);
        byteEn     = '1;
        wordOut    = wdata;
        rdata      = memWord;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory with one outstanding request over valid/ready,
// fixed LATENCY from accept to response, and misalign/range error reporting.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_type,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : '0;

  respStateT state, nextState;
  logic [3:0]  cnt, nextCnt;
  logic        doAccess;
  logic        accept;

  logic        lWrite, lUnsigned;
  logic [31:0] lAddr, lWdata;
  logic [1:0]  lType;

  logic        opWrite, opUnsigned;
  logic [31:0] opAddr, opWdata;
  logic [1:0]  opType;
  logic [IDXW-1:0] opIdx;

  logic [31:0] memWord, wAligned, alignRdata;
  logic [3:0]  byteEn;
  logic        misaligned, outOfRange, accErr;
  logic [31:0] respRdata;
  logic        respErr;

  logic [31:0] mem [DEPTH_WORDS];

  assign accept = (state == ST_IDLE) && req_valid;

  // With LATENCY=1 the access runs on the accept edge, before the request is
  // latched, so the operands come straight from the request port in IDLE.
  always_comb begin
    opWrite    = lWrite;
    opAddr     = lAddr;
    opWdata    = lWdata;
    opType     = lType;
    opUnsigned = lUnsigned;
    if (state == ST_IDLE) begin
      opWrite    = req_write;
      opAddr     = req_addr;
      opWdata    = req_wdata;
      opType     = req_type;
      opUnsigned = req_unsigned;
    end
  end

  assign opIdx      = opAddr[IDXW+1:2];
  assign memWord    = mem[opIdx];
  assign outOfRange = ({2'b00, opAddr[31:2]} >= DEPTH_WORDS);
  assign accErr     = misaligned || outOfRange;

  mem_lane_align uAlign (
    .addrLo     (opAddr[1:0]),
    .accType    (opType),
    .isUnsigned (opUnsigned),
    .wdata      (opWdata),
    .memWord    (memWord),
    .byteEn     (byteEn),
    .wordOut    (wAligned),
    .rdata      (alignRdata),
    .misaligned (misaligned)
  );

  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    doAccess  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            nextState = ST_RESP;
            doAccess  = 1'b1;
          end else begin
            nextState = ST_WAIT;
            nextCnt   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          nextState = ST_RESP;
          doAccess  = 1'b1;
        end else begin
          nextCnt = cnt - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) nextState = ST_IDLE;
      end
      default: nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      respRdata <= '0;
      respErr   <= 1'b0;
      lWrite    <= 1'b0;
      lAddr     <= '0;
      lWdata    <= '0;
      lType     <= '0;
      lUnsigned <= 1'b0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
      if (accept) begin
        lWrite    <= req_write;
        lAddr     <= req_addr;
        lWdata    <= req_wdata;
        lType     <= req_type;
        lUnsigned <= req_unsigned;
      end
      if (doAccess) begin
        respRdata <= (opWrite || accErr) ? '0 : alignRdata;
        respErr   <= accErr;
      end
    end
  end

  // Memory contents survive reset; a commit coinciding with reset is dropped.
  always_ff @(posedge Clk) begin
    if (!Reset && doAccess && opWrite && !accErr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byteEn[i]) mem[opIdx][8*i +: 8] <= wAligned[8*i +: 8];
      end
    end
  end

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign resp_rdata = respRdata;
  assign resp_err   = respErr;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: LATENCY=2 instance for the access
// rules, LATENCY=3 instance for reset-abandon of an uncommitted store.
module tb_data_mem_responder;
  import mem_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset2, Reset3;
  logic        reqValid, reqWrite, reqUnsigned, respReady;
  logic [31:0] reqAddr, reqWdata;
  logic [1:0]  reqType;

  logic        rdy2, rv2, err2, rdy3, rv3, err3;
  logic [31:0] rd2, rd3;

  logic        sel;
  logic        reqReady, respValid, respErr;
  logic [31:0] respRdata;

  int nAssert = 0;
  int nFail   = 0;

  always #5 Clk = ~Clk;

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .Clk(Clk), .Reset(Reset2), .req_valid(reqValid), .req_ready(rdy2),
    .req_write(reqWrite), .req_addr(reqAddr), .req_wdata(reqWdata),
    .req_type(reqType), .req_unsigned(reqUnsigned), .resp_valid(rv2),
    .resp_ready(respReady), .resp_rdata(rd2), .resp_err(err2)
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) dut3 (
    .Clk(Clk), .Reset(Reset3), .req_valid(reqValid), .req_ready(rdy3),
    .req_write(reqWrite), .req_addr(reqAddr), .req_wdata(reqWdata),
    .req_type(reqType), .req_unsigned(reqUnsigned), .resp_valid(rv3),
    .resp_ready(respReady), .resp_rdata(rd3), .resp_err(err3)
  );

  always_comb begin
    reqReady  = sel ? rdy3 : rdy2;
    respValid = sel ? rv3  : rv2;
    respRdata = sel ? rd3  : rd2;
    respErr   = sel ? err3 : err2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called and returns at a negedge; completes the handshake when respReady=1.
  task automatic transact(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] ty, input logic uns,
                          input int lat, input logic [31:0] expData, input logic expErr);
    int cycles;
    int guard;
    guard = 0;
    while (!reqReady && guard < 20) begin
      @(negedge Clk);
      guard++;
    end
    reqValid = 1'b1; reqWrite = wr; reqAddr = addr; reqWdata = wd;
    reqType = ty; reqUnsigned = uns;
    @(posedge Clk);
    @(negedge Clk);
    reqValid = 1'b0;
    cycles = 1;
    while (!respValid && cycles < 20) begin
      @(negedge Clk);
      cycles++;
    end
    check({tag, " latency"}, 32'(cycles), 32'(lat));
    check({tag, " rdata"}, respRdata, expData);
    check({tag, " err"}, {31'd0, respErr}, {31'd0, expErr});
    if (respReady) begin
      @(posedge Clk);
      @(negedge Clk);
    end
  endtask

  initial begin
    logic [31:0] heldData;
    logic        sawValid;
    sel = 1'b0;
    Reset2 = 1'b1; Reset3 = 1'b1;
    reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqWdata = '0;
    reqType = '0; reqUnsigned = 1'b0; respReady = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset2 = 1'b0;
    @(negedge Clk);
    check("reset req_ready", {31'd0, reqReady}, 32'd1);
    check("reset resp_valid", {31'd0, respValid}, 32'd0);
    check("reset rdata", respRdata, 32'd0);
    check("reset err", {31'd0, respErr}, 32'd0);

    transact("sw 0x10", 1'b1, 32'h10, 32'hDEADBEEF, MEM_WORD, 1'b0, 2, 32'h0, 1'b0);
    transact("lw 0x10", 1'b0, 32'h10, 32'h0, MEM_WORD, 1'b0, 2, 32'hDEADBEEF, 1'b0);
    transact("lb 0x13", 1'b0, 32'h13, 32'h0, MEM_BYTE, 1'b0, 2, 32'hFFFFFFDE, 1'b0);
    transact("lbu 0x13", 1'b0, 32'h13, 32'h0, MEM_BYTE, 1'b1, 2, 32'h000000DE, 1'b0);
    transact("lh 0x10", 1'b0, 32'h10, 32'h0, MEM_HALF, 1'b0, 2, 32'hFFFFBEEF, 1'b0);
    transact("lhu 0x12", 1'b0, 32'h12, 32'h0, MEM_HALF, 1'b1, 2, 32'h0000DEAD, 1'b0);
    transact("sb 0x11", 1'b1, 32'h11, 32'hAAAAAA55, MEM_BYTE, 1'b0, 2, 32'h0, 1'b0);
    transact("lw after sb", 1'b0, 32'h10, 32'h0, MEM_WORD, 1'b0, 2, 32'hDEAD55EF, 1'b0);

    transact("sw 0x20", 1'b1, 32'h20, 32'hCAFEF00D, MEM_WORD, 1'b0, 2, 32'h0, 1'b0);
    transact("lh 0x21 misalign", 1'b0, 32'h21, 32'h0, MEM_HALF, 1'b0, 2, 32'h0, 1'b1);
    transact("sw 0x22 misalign", 1'b1, 32'h22, 32'h11111111, MEM_WORD, 1'b0, 2, 32'h0, 1'b1);
    transact("lw 0x20 unchanged", 1'b0, 32'h20, 32'h0, MEM_WORD, 1'b0, 2, 32'hCAFEF00D, 1'b0);
    transact("lw out of range", 1'b0, 32'h1000, 32'h0, MEM_WORD, 1'b0, 2, 32'h0, 1'b1);
    transact("lrsvd 0x20", 1'b0, 32'h20, 32'h0, MEM_RSVD, 1'b0, 2, 32'hCAFEF00D, 1'b0);
    transact("lrsvd 0x21 misalign", 1'b0, 32'h21, 32'h0, MEM_RSVD, 1'b0, 2, 32'h0, 1'b1);
    transact("sh 0x22", 1'b1, 32'h22, 32'hFFFF1234, MEM_HALF, 1'b0, 2, 32'h0, 1'b0);
    transact("lw after sh", 1'b0, 32'h20, 32'h0, MEM_WORD, 1'b0, 2, 32'h1234F00D, 1'b0);

    respReady = 1'b0;
    transact("bp lw 0x10", 1'b0, 32'h10, 32'h0, MEM_WORD, 1'b0, 2, 32'hDEAD55EF, 1'b0);
    heldData = respRdata;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("bp resp_valid held", {31'd0, respValid}, 32'd1);
      check("bp rdata held", respRdata, heldData);
      check("bp req_ready low", {31'd0, reqReady}, 32'd0);
    end
    respReady = 1'b1;
    @(negedge Clk);
    check("bp release req_ready", {31'd0, reqReady}, 32'd1);
    check("bp release resp_valid", {31'd0, respValid}, 32'd0);

    Reset2 = 1'b1;
    sel = 1'b1;
    Reset3 = 1'b0;
    @(negedge Clk);
    transact("L3 sw 0x40", 1'b1, 32'h40, 32'h0BADF00D, MEM_WORD, 1'b0, 3, 32'h0, 1'b0);
    reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 32'h40; reqWdata = 32'h12345678;
    reqType = MEM_WORD; reqUnsigned = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    reqValid = 1'b0;
    Reset3 = 1'b1;
    @(negedge Clk);
    Reset3 = 1'b0;
    sawValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      sawValid = sawValid | respValid;
    end
    check("rst abandon resp_valid", {31'd0, sawValid}, 32'd0);
    check("rst abandon req_ready", {31'd0, reqReady}, 32'd1);
    transact("L3 lw 0x40 old", 1'b0, 32'h40, 32'h0, MEM_WORD, 1'b0, 3, 32'h0BADF00D, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
